// File: rtl/if_fetch_unit_pkg.sv
// ---------------------------------------------------------------------------
// if_fetch_unit_pkg
// Shared types and constants for the instruction-fetch stage.
//   DEF_ADDR_W / DEF_DATA_W : default instruction address / word widths
//   NOP                     : instruction word loaded into IF/ID on reset
//   fetch_state_e           : fetch FSM state encoding
// ---------------------------------------------------------------------------
package if_fetch_unit_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  localparam logic [31:0] NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // request low for one cycle (after reset or redirect)
    ST_REQ  = 2'd1,  // request presented, waiting for grant
    ST_WAIT = 2'd2,  // granted, waiting for the response strobe
    ST_HOLD = 2'd3   // response parked in the skid entry, decode stalled
  } fetch_state_e;

endpackage : if_fetch_unit_pkg

// File: rtl/if_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// if_fetch_unit_if
// Instruction-memory request/grant/response bundle.
//   req    : fetch request, held until granted       (master -> slave)
//   addr   : request address                         (master -> slave)
//   gnt    : memory accepts the request this cycle   (slave -> master)
//   rvalid : response strobe                         (slave -> master)
//   rdata  : response instruction word               (slave -> master)
// Modports: master = fetch unit, slave = instruction memory.
// ---------------------------------------------------------------------------
interface if_fetch_unit_if
  import if_fetch_unit_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              req;
  logic [ADDR_W-1:0] addr;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req,
    output addr,
    input  gnt,
    input  rvalid,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output gnt,
    output rvalid,
    output rdata
  );

endinterface : if_fetch_unit_if

// File: rtl/if_fetch_unit_skid.sv
// ---------------------------------------------------------------------------
// if_fetch_unit_skid
// One-entry holding register that parks a returned instruction while decode
// is stalled and IF/ID is occupied.
//   clk_i   : clock, rising edge
//   rst_i   : asynchronous active-high reset (entry emptied)
//   load_i  : capture data_i, entry becomes valid
//   drop_i  : empty the entry (consumed or flushed)
//   data_i  : instruction word to park
//   valid_o : entry holds an instruction
//   data_o  : parked instruction word
// ---------------------------------------------------------------------------
module if_fetch_unit_skid
  import if_fetch_unit_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic              drop_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q;
  logic [DATA_W-1:0] data_q;

  // Load wins over drop; the fetch FSM never asks for both together.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
    end else if (drop_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule : if_fetch_unit_skid

// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
// Instruction-fetch stage. Issues one instruction-memory request at a time
// for the current PC, captures the response with its address into the IF/ID
// register, tells the PC when to advance, and absorbs decode stalls (via a
// one-entry skid) and branch redirects (flush).
//   clk_i         : clock, rising edge
//   rst_i         : asynchronous active-high reset
//   pc_in_i       : current PC value
//   pc_write_o    : PC may load its next value this edge
//   imem          : instruction-memory request/grant/response (master side)
//   id_stall_i    : decode holds IF/ID
//   flush_i       : redirect; discard current fetch and IF/ID contents
//   if_id_valid_o : IF/ID holds a live instruction
//   if_id_instr_o : fetched instruction
//   if_id_pc_o    : address of if_id_instr_o
// ---------------------------------------------------------------------------
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] pc_in_i,
  output logic              pc_write_o,
  if_fetch_unit_if.master   imem,
  input  logic              id_stall_i,
  input  logic              flush_i,
  output logic              if_id_valid_o,
  output logic [DATA_W-1:0] if_id_instr_o,
  output logic [ADDR_W-1:0] if_id_pc_o
);

  fetch_state_e      state_q, state_d;
  logic              discard_q, discard_d;

  logic              if_id_valid_q;
  logic [DATA_W-1:0] if_id_instr_q;
  logic [ADDR_W-1:0] if_id_pc_q;

  logic              fetch_req;
  logic              pc_write;
  logic              ifid_load;
  logic [DATA_W-1:0] ifid_data;
  logic              skid_load;
  logic              skid_drop;
  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic              slot_free;

  // IF/ID can accept a new instruction if it is empty or decode is taking
  // the current one this cycle.
  assign slot_free = !if_id_valid_q || !id_stall_i;

  // -------------------------------------------------------------------------
  // Skid entry
  // -------------------------------------------------------------------------
  if_fetch_unit_skid #(
    .DATA_W (DATA_W)
  ) u_skid (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (skid_load),
    .drop_i  (skid_drop),
    .data_i  (imem.rdata),
    .valid_o (skid_valid),
    .data_o  (skid_data)
  );

  // -------------------------------------------------------------------------
  // FSM state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      discard_q <= discard_d;
    end
  end

  // -------------------------------------------------------------------------
  // FSM next-state and outputs
  // -------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    discard_d = discard_q;
    fetch_req = 1'b0;
    pc_write  = 1'b0;
    ifid_load = 1'b0;
    ifid_data = imem.rdata;
    skid_load = 1'b0;
    skid_drop = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        state_d = ST_REQ;
      end

      ST_REQ: begin
        fetch_req = 1'b1;
        if (imem.gnt) begin
          // A flush in the grant cycle still leaves a response in flight;
          // remember to throw it away when it arrives.
          state_d = ST_WAIT;
          if (flush_i) begin
            discard_d = 1'b1;
          end
        end else if (flush_i) begin
          // Drop the request for a cycle while the PC takes the redirect.
          state_d = ST_IDLE;
        end
      end

      ST_WAIT: begin
        if (imem.rvalid) begin
          if (discard_q || flush_i) begin
            discard_d = 1'b0;
            state_d   = ST_REQ;
          end else if (slot_free) begin
            ifid_load = 1'b1;
            pc_write  = 1'b1;
            state_d   = ST_REQ;
          end else begin
            skid_load = 1'b1;
            state_d   = ST_HOLD;
          end
        end else if (flush_i) begin
          discard_d = 1'b1;
        end
      end

      ST_HOLD: begin
        if (flush_i) begin
          skid_drop = 1'b1;
          state_d   = ST_REQ;
        end else if (!id_stall_i && skid_valid) begin
          // IF/ID is being consumed this cycle; refill it from the skid.
          ifid_load = 1'b1;
          ifid_data = skid_data;
          pc_write  = 1'b1;
          skid_drop = 1'b1;
          state_d   = ST_REQ;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // IF/ID pipeline register. Instr/PC only change on a load, so they keep
  // their last values while Valid is low.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      if_id_valid_q <= 1'b0;
      if_id_instr_q <= DATA_W'(NOP);
      if_id_pc_q    <= '0;
    end else if (flush_i) begin
      if_id_valid_q <= 1'b0;
    end else if (ifid_load) begin
      if_id_valid_q <= 1'b1;
      if_id_instr_q <= ifid_data;
      if_id_pc_q    <= pc_in_i;
    end else if (!id_stall_i) begin
      if_id_valid_q <= 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign imem.req      = fetch_req;
  assign imem.addr     = pc_in_i;
  assign pc_write_o    = pc_write;
  assign if_id_valid_o = if_id_valid_q;
  assign if_id_instr_o = if_id_instr_q;
  assign if_id_pc_o    = if_id_pc_q;

endmodule : if_fetch_unit

// File: tb/tb_if_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_unit
// Randomized bench for the fetch stage. A memory model answers granted
// requests with a word derived from the address; a program-order model
// predicts which instructions decode must see (sequential PCs, restarting at
// the target after each redirect). The stimulus side pushes expectations
// into a queue; a separate negedge monitor pops and compares each time
// decode consumes an IF/ID entry.
// ---------------------------------------------------------------------------
module tb_if_fetch_unit;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in;
  logic        pc_write;
  logic        id_stall;
  logic        flush;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;

  if_fetch_unit_if bus ();

  if_fetch_unit dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .pc_in_i       (pc_in),
    .pc_write_o    (pc_write),
    .imem          (bus),
    .id_stall_i    (id_stall),
    .flush_i       (flush),
    .if_id_valid_o (if_id_valid),
    .if_id_instr_o (if_id_instr),
    .if_id_pc_o    (if_id_pc)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t q[$];

  // environment / model state
  logic [31:0] pc_model;    // architectural PC register driving pc_in
  logic [31:0] prog_pc;     // next instruction decode should receive
  logic [31:0] flush_tgt;
  logic [31:0] rec_addr;    // address of the granted request
  logic        outstanding;
  logic        killed;
  logic        resp_now;
  int          delay;
  logic        mon_en;
  logic        gnt_en;
  logic        flush_en;
  logic        stall_en;
  logic        req_s;
  logic [31:0] addr_s;
  logic        pw_s;

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Memory contents: a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // -------------------------------------------------------------------------
  // Monitor
  // -------------------------------------------------------------------------
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.req) begin
        check("req_addr", bus.addr, pc_in);
        if (outstanding) check("one_outstanding", {31'd0, bus.req}, 32'd0);
      end
      if (if_id_valid && !id_stall && !flush) begin
        if (q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_instr: got pc %h instr %h expected none",
                   if_id_pc, if_id_instr);
        end else begin
          exp_t e;
          e = q.pop_front();
          $display("consume pc=%h instr=%h", if_id_pc, if_id_instr);
          check("ifid_pc", if_id_pc, e.pc);
          check("ifid_instr", if_id_instr, e.instr);
        end
      end
    end
  end

  // Apply the effect of the edge that just passed to the models.
  task automatic update_models();
    if (flush)     pc_model = flush_tgt;
    else if (pw_s) pc_model = pc_model + 32'd4;
    if (resp_now) outstanding = 1'b0;
    if (bus.gnt && req_s) begin
      outstanding = 1'b1;
      killed      = flush;
      delay       = $urandom_range(0, 2);
      rec_addr    = addr_s;
    end else if (flush && outstanding) begin
      killed = 1'b1;
    end
  endtask

  // Choose inputs for the coming cycle.
  task automatic drive_inputs();
    pc_in    = pc_model;
    flush    = flush_en && ($urandom_range(0, 11) == 0);
    if (flush) begin
      flush_tgt = $urandom & 32'h0000_FFFC;
      prog_pc   = flush_tgt;
      q.delete();
    end
    id_stall = stall_en && ($urandom_range(0, 9) < 4);
    resp_now = 1'b0;
    if (outstanding) begin
      if (delay == 0) begin
        resp_now   = 1'b1;
        bus.rvalid = 1'b1;
        bus.rdata  = mem_word(rec_addr);
        if (!killed && !flush) begin
          q.push_back({prog_pc, mem_word(prog_pc)});
          prog_pc = prog_pc + 32'd4;
        end
      end else begin
        delay--;
        bus.rvalid = 1'b0;
        bus.rdata  = $urandom;
      end
    end else begin
      // stray strobe with no request in flight: must be ignored
      bus.rvalid = ($urandom_range(0, 9) == 0);
      bus.rdata  = $urandom;
    end
    bus.gnt = gnt_en && ($urandom_range(0, 1) == 1);
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      req_s  = bus.req;
      addr_s = bus.addr;
      pw_s   = pc_write;
      @(posedge clk);
      #1;
      update_models();
      drive_inputs();
      @(negedge clk);
    end
  endtask

  // -------------------------------------------------------------------------
  // Main sequence
  // -------------------------------------------------------------------------
  initial begin
    mon_en      = 1'b0;
    gnt_en      = 1'b1;
    flush_en    = 1'b1;
    stall_en    = 1'b1;
    outstanding = 1'b0;
    killed      = 1'b0;
    resp_now    = 1'b0;
    delay       = 0;
    flush_tgt   = 32'd0;
    rec_addr    = 32'd0;

    // Reset with random inputs: every output low.
    rst        = 1'b1;
    pc_in      = $urandom;
    id_stall   = 1'($urandom);
    flush      = 1'($urandom);
    bus.gnt    = 1'($urandom);
    bus.rvalid = 1'($urandom);
    bus.rdata  = $urandom;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst_req",      {31'd0, bus.req},     32'd0);
      check("rst_pc_write", {31'd0, pc_write},    32'd0);
      check("rst_valid",    {31'd0, if_id_valid}, 32'd0);
      check("rst_instr",    if_id_instr,          32'd0);
      check("rst_pc",       if_id_pc,             32'd0);
    end

    @(posedge clk);
    #1;
    rst        = 1'b0;
    pc_in      = 32'd0;
    id_stall   = 1'b0;
    flush      = 1'b0;
    bus.gnt    = 1'b0;
    bus.rvalid = 1'b0;
    bus.rdata  = 32'd0;
    @(negedge clk);
    check("rel_cyc1_req", {31'd0, bus.req}, 32'd0);
    @(negedge clk);
    check("rel_cyc2_req",  {31'd0, bus.req}, 32'd1);
    check("rel_cyc2_addr", bus.addr,         32'd0);

    // Random traffic.
    pc_model = 32'd0;
    prog_pc  = 32'd0;
    mon_en   = 1'b1;
    run_cycles(3000);

    // Drain: no new grants, no stalls, no redirects.
    gnt_en   = 1'b0;
    flush_en = 1'b0;
    stall_en = 1'b0;
    run_cycles(15);
    check("drain_queue_empty", q.size(), 32'd0);
    mon_en = 1'b0;

    // Reset in the middle of a fetch; a late response must be ignored.
    @(posedge clk);
    #1;
    bus.gnt    = 1'b1;
    bus.rvalid = 1'b0;
    @(posedge clk);
    #1;
    bus.gnt = 1'b0;          // now waiting for the response
    #2;
    rst = 1'b1;
    #1;
    check("midrst_req",   {31'd0, bus.req},     32'd0);
    check("midrst_valid", {31'd0, if_id_valid}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      bus.rvalid = 1'b1;
      bus.rdata  = 32'hDEAD_BEEF;
      @(negedge clk);
      check("midrst_pc_write", {31'd0, pc_write}, 32'd0);
    end
    @(posedge clk);
    #1;
    bus.rvalid = 1'b0;
    @(negedge clk);
    check("midrst_late_valid", {31'd0, if_id_valid}, 32'd0);
    check("midrst_late_req",   {31'd0, bus.req},     32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule : tb_if_fetch_unit

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage that reads the program counter and drives the IF/ID pipeline register. It takes the PC value, issues one request at a time to instruction memory over a request/grant/response handshake, and captures the returned instruction together with its address into IF/ID. It tells the PC when it may advance and absorbs back-pressure from decode (ID stall) as well as branch redirects (flush).

## Interface
- ADDR_W, 32, instruction address width
- DATA_W, 32, instruction word width
- Clk  in  1  clock, rising edge
- Rst  in  1  asynchronous, active-high reset
- PC_In  in  ADDR_W  current PC value
- PC_Write  out  1  1 = PC may load its next value this edge
- IMem_Req  out  1  fetch request, held until granted
- IMem_Addr  out  ADDR_W  request address, equals PC_In while IMem_Req=1
- IMem_Gnt  in  1  memory accepts request this cycle
- IMem_Rvalid  in  1  response valid strobe
- IMem_Rdata  in  DATA_W  response instruction
- ID_Stall  in  1  decode holds IF/ID
- Flush  in  1  branch redirect; discard current fetch and IF/ID contents
- IF_ID_Valid  out  1  IF/ID holds a live instruction
- IF_ID_Instr  out  DATA_W  fetched instruction
- IF_ID_PC  out  ADDR_W  address of IF_ID_Instr

## Operation
- FSM states: IDLE, REQ, WAIT, HOLD.
- IDLE: drive IMem_Req=0. Go to REQ on the next edge.
- REQ: drive IMem_Req=1 and IMem_Addr=PC_In. On Gnt, go to WAIT.
  - Flush without Gnt: go to IDLE, so the request drops for one cycle while the PC is redirected.
  - Flush together with Gnt: go to WAIT with discard=1.
- WAIT: wait for Rvalid. Define slot_free = !IF_ID_Valid | !ID_Stall.
  - Rvalid with discard=1 or Flush: drop the data, clear discard, go to REQ.
  - Rvalid with slot_free: load IF/ID (Instr=Rdata, PC=PC_In, Valid=1), assert PC_Write, go to REQ.
  - Rvalid without slot_free: store Rdata in the skid entry, go to HOLD.
  - Flush without Rvalid: set discard=1, stay in WAIT.
- HOLD: once ID_Stall=0, load IF/ID from the skid entry, assert PC_Write, go to REQ. Flush drops the skid entry and goes to REQ.
- PC_Write is combinational from state and inputs, and is high for exactly one cycle per accepted instruction. The PC changes only on PC_Write or on an external redirect accompanied by Flush, so PC_In stays stable through REQ, WAIT and HOLD.
- IF/ID update rules:
  - Flush clears IF_ID_Valid (highest priority).
  - Otherwise a load sets Valid=1.
  - Otherwise, if ID_Stall=0, Valid goes to 0 (bubble).
  - Otherwise IF/ID holds.
  - Instr and PC keep their old values whenever Valid=0.
- Only one request is outstanding at a time. A Gnt outside REQ and an Rvalid outside WAIT/discard are ignored.

## Timing
- Reset, applied asynchronously:
  - state=IDLE, discard=0, skid entry empty.
  - IMem_Req=0, PC_Write=0.
  - IF_ID_Valid=0, IF_ID_Instr=0 (NOP), IF_ID_PC=0.
- First request is visible in the second cycle after Rst deasserts.
- Gnt may arrive in the same cycle Req rises. Rvalid arrives no earlier than the cycle after Gnt.
- Best-case throughput is one instruction every 2 cycles (REQ+Gnt, then WAIT+Rvalid).
- IF/ID output is registered: data appears the edge after Rvalid is accepted.
- Rst during REQ/WAIT/HOLD aborts the fetch. A stale Rvalid that arrives after reset lands in IDLE/REQ and is ignored.

## Structure
- Shared package pipe_pkg holds:
  - the fetch state enum;
  - the NOP constant (32'h0000_0000);
  - default ADDR_W/DATA_W.
- Sub-module fetch_skid: a one-entry holding register with load, drop and valid.
- Expected implementation size: ~200 lines total.

## Test plan
- Reset: Rst=1 for 2 cycles with random inputs → all outputs 0. Release → IMem_Req=1 with IMem_Addr=0x00000000 in the 2nd cycle.
- Basic fetch: PC_In=0x100, Gnt in the same cycle, Rvalid next cycle with Rdata=0x8C010004 → PC_Write pulses once. Next edge: IF_ID_Valid=1, IF_ID_Instr=0x8C010004, IF_ID_PC=0x100.
- Back-pressure: IF/ID valid with ID_Stall=1, Rvalid with 0x20020005 → HOLD, PC_Write=0, IF/ID unchanged. Drop ID_Stall → IF_ID_Instr=0x20020005 and one PC_Write pulse.
- Flush in WAIT: Flush the cycle after Gnt, PC redirected to 0x200, Rvalid 2 cycles later → data dropped, IF_ID_Valid=0, no PC_Write, next request has IMem_Addr=0x200.
- Grant delay: Gnt held low 3 cycles → IMem_Req=1 and IMem_Addr constant throughout, PC_Write=0.
- Reset mid-fetch: Rst pulse in WAIT, Rvalid one cycle after release → IMem_Req drops immediately, Rvalid ignored, IF_ID_Valid stays 0.
